ldq_violation_buffer: RTL

LDQ_VIOLATION_BUFFER -- requirements
Module: ldq_violation_buffer

---
 rtl/ldq_violation_buffer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ldq_violation_buffer.sv
// Load-queue violation buffer: tracks in-flight loads and flags the oldest load
// younger than a resolving store that overlaps its address word and byte mask.
module ldq_violation_buffer #(
   parameter int DEPTH    = 16,
   parameter int TAG_W    = 6,
   parameter int ADDR_W   = 32,
   parameter int COMMIT_W = 2,
   parameter int PCX_W    = 10,
   parameter int SSID_W   = 7
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       alloc_valid,
   output logic                       alloc_ready,
   input  logic [ADDR_W-1:0]          alloc_addr,
   input  logic [3:0]                 alloc_mask,
   input  logic [TAG_W-1:0]           alloc_tag,
   input  logic [PCX_W-1:0]           alloc_pcx,
   input  logic [SSID_W-1:0]          alloc_ssid,
   input  logic [TAG_W-1:0]           head_tag,
   input  logic [COMMIT_W-1:0]        commit_valid,
   input  logic                       flush_valid,
   input  logic [TAG_W-1:0]           flush_tag,
   input  logic                       st_valid,
   input  logic [ADDR_W-1:0]          st_addr,
   input  logic [3:0]                 st_mask,
   input  logic [TAG_W-1:0]           st_tag,
   output logic                       viol_valid,
   output logic [TAG_W-1:0]           viol_tag,
   output logic [PCX_W-1:0]           viol_pcx,
   output logic [SSID_W-1:0]          viol_ssid,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0]  r_valid;
   logic [ADDR_W-1:0] r_addr [DEPTH];
   logic [3:0]        r_mask [DEPTH];
   logic [TAG_W-1:0]  r_tag  [DEPTH];
   logic [PCX_W-1:0]  r_pcx  [DEPTH];
   logic [SSID_W-1:0] r_ssid [DEPTH];

   logic              r_viol_valid;
   logic [TAG_W-1:0]  r_viol_tag;
   logic [PCX_W-1:0]  r_viol_pcx;
   logic [SSID_W-1:0] r_viol_ssid;

   logic [TAG_W-1:0]  w_age [DEPTH];
   logic [TAG_W-1:0]  w_flush_age;
   logic [TAG_W-1:0]  w_st_age;
   logic [DEPTH-1:0]  w_kill;
   logic [DEPTH-1:0]  w_commit;
   logic [DEPTH-1:0]  w_match;
   logic [DEPTH-1:0]  w_alloc_onehot;
   logic [DEPTH-1:0]  w_valid_next;
   logic              w_alloc_fire;
   logic              w_viol_fire;
   logic [IDX_W-1:0]  w_free_idx;
   logic [CNT_W-1:0]  w_count;
   logic              w_found;
   logic [IDX_W-1:0]  w_sel_idx;
   logic [TAG_W-1:0]  w_sel_age;

   assign w_flush_age = flush_tag - head_tag;
   assign w_st_age    = st_tag - head_tag;

   // Ages are relative to the current head so wrapped tags compare correctly.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic w_commit_hit;
         always_comb begin
            w_commit_hit = 1'b0;
            for (int c = 0; c < COMMIT_W; c++) begin
               if (commit_valid[c] && (r_tag[gi] == head_tag + TAG_W'(c))) begin
                  w_commit_hit = 1'b1;
               end
            end
         end
         assign w_age[gi]          = r_tag[gi] - head_tag;
         assign w_kill[gi]         = r_valid[gi] & flush_valid & (w_age[gi] > w_flush_age);
         assign w_commit[gi]       = r_valid[gi] & w_commit_hit;
         assign w_match[gi]        = r_valid[gi]
                                   & (r_addr[gi][ADDR_W-1:2] == st_addr[ADDR_W-1:2])
                                   & (|(r_mask[gi] & st_mask))
                                   & (w_age[gi] > w_st_age);
         assign w_alloc_onehot[gi] = w_alloc_fire & (w_free_idx == IDX_W'(gi));
      end
   endgenerate

   always_comb begin
      w_free_idx = '0;
      w_count    = '0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (!r_valid[i]) w_free_idx = IDX_W'(i);
         w_count = w_count + CNT_W'(r_valid[i]);
      end
   end

   // Ascending scan with strict compare keeps the lowest index on an age tie.
   always_comb begin
      w_found   = 1'b0;
      w_sel_idx = '0;
      w_sel_age = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_match[i] && (!w_found || (w_age[i] < w_sel_age))) begin
            w_found   = 1'b1;
            w_sel_idx = IDX_W'(i);
            w_sel_age = w_age[i];
         end
      end
   end

   assign full         = (w_count == CNT_W'(DEPTH));
   assign empty        = (w_count == '0);
   assign count        = w_count;
   assign alloc_ready  = ~full;
   assign w_alloc_fire = alloc_valid & ~full & ~flush_valid;
   assign w_viol_fire  = st_valid & ~flush_valid & w_found;
   // Kill/commit only touch valid entries and allocation only a free one.
   assign w_valid_next = (r_valid & ~w_kill & ~w_commit) | w_alloc_onehot;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
      end else begin
         r_valid <= w_valid_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && w_alloc_fire) begin
         r_addr[w_free_idx] <= alloc_addr;
         r_mask[w_free_idx] <= alloc_mask;
         r_tag[w_free_idx]  <= alloc_tag;
         r_pcx[w_free_idx]  <= alloc_pcx;
         r_ssid[w_free_idx] <= alloc_ssid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_viol_valid <= 1'b0;
         r_viol_tag   <= '0;
         r_viol_pcx   <= '0;
         r_viol_ssid  <= '0;
      end else begin
         r_viol_valid <= w_viol_fire;
         if (w_viol_fire) begin
            r_viol_tag  <= r_tag[w_sel_idx];
            r_viol_pcx  <= r_pcx[w_sel_idx];
            r_viol_ssid <= r_ssid[w_sel_idx];
         end
      end
   end

   assign viol_valid = r_viol_valid;
   assign viol_tag   = r_viol_tag;
   assign viol_pcx   = r_viol_pcx;
   assign viol_ssid  = r_viol_ssid;

endmodule
